// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and mode encodings for the VGA pattern path
package vga_pkg;

  localparam int H_VALID_DEF = 640;
  localparam int V_VALID_DEF = 480;

  typedef enum logic [1:0] {
    MODE_BARS   = 2'd0,
    MODE_CIRCLE = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_CHECK  = 2'd3
  } mode_e;

  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] ORANGE = 16'hFC00;
  localparam logic [15:0] YELLOW = 16'hFFE0;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] CYAN   = 16'h07FF;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] PURPLE = 16'h801F;
  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] GRAY   = 16'hD69A;

  // Bar colour for a saturated bar index, left to right across the line
  function automatic logic [15:0] bar_colour(input logic [3:0] idx);
    case (idx)
      4'd0:    bar_colour = RED;
      4'd1:    bar_colour = ORANGE;
      4'd2:    bar_colour = YELLOW;
      4'd3:    bar_colour = GREEN;
      4'd4:    bar_colour = CYAN;
      4'd5:    bar_colour = BLUE;
      4'd6:    bar_colour = PURPLE;
      4'd7:    bar_colour = BLACK;
      4'd8:    bar_colour = WHITE;
      default: bar_colour = GRAY;
    endcase
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - pixel request / colour response bundle
interface vga_pattern_gen_if;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pix_req;
  logic [15:0] pix_colour;
  logic        pix_colour_vld;

  modport master (
    output pix_x, pix_y, pix_req,
    input  pix_colour, pix_colour_vld
  );

  modport slave (
    input  pix_x, pix_y, pix_req,
    output pix_colour, pix_colour_vld
  );
endinterface

// File: rtl/vga_circle_hit.sv
// rtl/vga_circle_hit.sv - two-stage squared-distance inside-circle test
module vga_circle_hit #(
  parameter int RADIUS = 50
) (
  input  logic       Clk_int,
  input  logic       Sys_Rst_n,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] cx,
  input  logic [9:0] cy,
  output logic       hit
);

  localparam logic [21:0] R_SQ = 22'(RADIUS * RADIUS);

  logic signed [10:0] dx_d, dx_q, dy_d, dy_q;
  logic               hit_d, hit_q;
  logic [10:0]        adx, ady;
  logic [21:0]        dist_sq;

  // Stage 1: signed offsets from the centre
  always_comb begin
    dx_d = $signed({1'b0, x}) - $signed({1'b0, cx});
    dy_d = $signed({1'b0, y}) - $signed({1'b0, cy});
  end

  // Stage 2: magnitudes squared and summed at full width; boundary counts as inside
  always_comb begin
    adx     = dx_q[10] ? (~dx_q + 11'sd1) : dx_q;
    ady     = dy_q[10] ? (~dy_q + 11'sd1) : dy_q;
    dist_sq = 22'(adx) * 22'(adx) + 22'(ady) * 22'(ady);
    hit_d   = (dist_sq <= R_SQ);
  end

  // Pipeline registers
  always_ff @(posedge Clk_int or negedge Sys_Rst_n) begin
    if (!Sys_Rst_n) begin
      dx_q  <= '0;
      dy_q  <= '0;
      hit_q <= 1'b0;
    end else begin
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      hit_q <= hit_d;
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - RGB565 test-pattern source with fixed two-cycle latency
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int          H_VALID    = H_VALID_DEF,
  parameter int          V_VALID    = V_VALID_DEF,
  parameter int          RADIUS     = 50,
  parameter int          INIT_X     = 320,
  parameter int          INIT_Y     = 240,
  parameter int          STEP       = 4,
  parameter logic [15:0] FG_COLOUR  = 16'hF800,
  parameter logic [15:0] BG_COLOUR  = 16'h0000,
  parameter int          CHECK_LOG2 = 5,
  parameter int          LATENCY    = 2
) (
  input  logic                Clk_int,
  input  logic                Sys_Rst_n,
  vga_pattern_gen_if.slave    pix_if,
  input  logic [1:0]          mode_sel,
  input  logic                pause
);

  if (LATENCY != 2 || RADIUS < 1 || STEP < 1 || STEP > RADIUS) begin : g_bad_params
    $error("vga_pattern_gen: unsupported parameter set");
  end

  mode_e       active_mode_d, active_mode_q;
  logic [9:0]  cx_d, cx_q, cy_d, cy_q;
  logic        dir_x_d, dir_x_q, dir_y_d, dir_y_q;
  logic        frame_tick;

  logic        req1_d, req1_q, req2_d, req2_q;
  logic [3:0]  bar1_d, bar1_q, bar2_d, bar2_q;
  logic        chk1_d, chk1_q, chk2_d, chk2_q;
  mode_e       mode1_d, mode1_q, mode2_d, mode2_q;
  logic [9:0]  bar_raw;
  logic [9:0]  centre_x, centre_y;
  logic        hit;
  logic [15:0] colour;

  // One axis of ball motion: returns {new_dir, new_pos}, clamping on the wall
  function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic dir,
                                            input logic [10:0] max_pos);
    if (!dir) begin
      if ({1'b0, pos} + 11'(STEP + RADIUS) > max_pos)
        step_axis = {1'b1, 10'(max_pos - 11'(RADIUS))};
      else
        step_axis = {1'b0, pos + 10'(STEP)};
    end else begin
      if ({1'b0, pos} < 11'(RADIUS + STEP))
        step_axis = {1'b0, 10'(RADIUS)};
      else
        step_axis = {1'b1, pos - 10'(STEP)};
    end
  endfunction

  assign frame_tick = pix_if.pix_req && (pix_if.pix_x == 10'(H_VALID - 1))
                                     && (pix_if.pix_y == 10'(V_VALID - 1));

  // Frame-rate state: mode latch and ball motion, applied after the last pixel
  always_comb begin
    active_mode_d = active_mode_q;
    cx_d          = cx_q;
    cy_d          = cy_q;
    dir_x_d       = dir_x_q;
    dir_y_d       = dir_y_q;
    if (frame_tick) begin
      active_mode_d = mode_e'(mode_sel);
      if (active_mode_q == MODE_BOUNCE && !pause) begin
        {dir_x_d, cx_d} = step_axis(cx_q, dir_x_q, 11'(H_VALID - 1));
        {dir_y_d, cy_d} = step_axis(cy_q, dir_y_q, 11'(V_VALID - 1));
      end
    end
  end

  // Stage 1: bar index, checker bit and mode travel alongside the request
  always_comb begin
    bar_raw  = pix_if.pix_x / 10'(H_VALID / 10);
    req1_d   = pix_if.pix_req;
    bar1_d   = (bar_raw > 10'd9) ? 4'd9 : bar_raw[3:0];
    chk1_d   = pix_if.pix_x[CHECK_LOG2] ^ pix_if.pix_y[CHECK_LOG2];
    mode1_d  = active_mode_q;
    centre_x = (active_mode_q == MODE_BOUNCE) ? cx_q : 10'(INIT_X);
    centre_y = (active_mode_q == MODE_BOUNCE) ? cy_q : 10'(INIT_Y);
  end

  // Stage 2: delay the side-band fields to line up with the registered hit
  always_comb begin
    req2_d  = req1_q;
    bar2_d  = bar1_q;
    chk2_d  = chk1_q;
    mode2_d = mode1_q;
  end

  // State and pipeline registers
  always_ff @(posedge Clk_int or negedge Sys_Rst_n) begin
    if (!Sys_Rst_n) begin
      active_mode_q <= MODE_BARS;
      cx_q          <= 10'(INIT_X);
      cy_q          <= 10'(INIT_Y);
      dir_x_q       <= 1'b0;
      dir_y_q       <= 1'b0;
      req1_q        <= 1'b0;
      req2_q        <= 1'b0;
      bar1_q        <= '0;
      bar2_q        <= '0;
      chk1_q        <= 1'b0;
      chk2_q        <= 1'b0;
      mode1_q       <= MODE_BARS;
      mode2_q       <= MODE_BARS;
    end else begin
      active_mode_q <= active_mode_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      req1_q        <= req1_d;
      req2_q        <= req2_d;
      bar1_q        <= bar1_d;
      bar2_q        <= bar2_d;
      chk1_q        <= chk1_d;
      chk2_q        <= chk2_d;
      mode1_q       <= mode1_d;
      mode2_q       <= mode2_d;
    end
  end

  vga_circle_hit #(
    .RADIUS (RADIUS)
  ) u_circle_hit (
    .Clk_int   (Clk_int),
    .Sys_Rst_n (Sys_Rst_n),
    .x         (pix_if.pix_x),
    .y         (pix_if.pix_y),
    .cx        (centre_x),
    .cy        (centre_y),
    .hit       (hit)
  );

  // Output colour select; blank whenever no request reached stage 2
  always_comb begin
    colour = 16'h0000;
    if (req2_q) begin
      case (mode2_q)
        MODE_BARS:   colour = bar_colour(bar2_q);
        MODE_CIRCLE,
        MODE_BOUNCE: colour = hit ? FG_COLOUR : BG_COLOUR;
        default:     colour = chk2_q ? WHITE : BLACK;
      endcase
    end
  end

  assign pix_if.pix_colour     = colour;
  assign pix_if.pix_colour_vld = req2_q;

endmodule
